// File: rtl/restador_bcd_serial.sv
// ---------------------------------------------------------------------------
// restador_bcd_serial
//
// Serial multi-digit BCD subtractor. Computes |A - B| one BCD digit per clock,
// least-significant digit first, as A + nine's-complement(B) + 1 with the
// usual +6 decimal correction on every digit. When the final carry shows the
// result is negative, a second serial pass replaces the partial result with
// its ten's complement, which is the magnitude.
//
// Handshake (start/done):
//   - inicio is sampled only while idle (REPOSO). A cycle with inicio=1 in
//     REPOSO captures A and B and starts an operation; inicio at any other
//     time is ignored and never queued.
//   - ocupado is high from the cycle after the capturing edge until the
//     result is ready; it falls in the same cycle that listo pulses.
//   - listo is a single-cycle pulse. Z, negativo and error_bcd are valid in
//     that cycle and hold until the next accepted inicio.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous, active-high reset (aborts any operation)
//   inicio    in   start request
//   A         in   minuend, packed BCD, digit 0 in bits [3:0]
//   B         in   subtrahend, packed BCD
//   Z         out  magnitude |A-B|, packed BCD
//   negativo  out  1 when A < B
//   listo     out  one-cycle done pulse
//   ocupado   out  operation in progress
//   error_bcd out  a captured digit was greater than 9
//
// Latency from the capturing edge to the listo cycle:
//   A >= B        : DIGITOS edges
//   A <  B        : 2*DIGITOS edges
//   invalid digit : 1 edge
// ---------------------------------------------------------------------------
module restador_bcd_serial #(
  parameter int DIGITOS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inicio,
  input  logic [4*DIGITOS-1:0] A,
  input  logic [4*DIGITOS-1:0] B,
  output logic [4*DIGITOS-1:0] Z,
  output logic                 negativo,
  output logic                 listo,
  output logic                 ocupado,
  output logic                 error_bcd
);

  localparam int W  = 4 * DIGITOS;
  localparam int IW = (DIGITOS > 1) ? $clog2(DIGITOS) : 1;

  // FSM state is kept in the enum-typed register 'estado' so that checkers
  // can observe it hierarchically.
  typedef enum logic [1:0] {
    REPOSO      = 2'd0,
    RESTA       = 2'd1,
    COMPLEMENTO = 2'd2,
    FIN         = 2'd3
  } estado_t;

  estado_t         estado;
  estado_t         estado_n;

  logic [W-1:0]    a_r;
  logic [W-1:0]    b_r;
  logic [W-1:0]    z_r;
  logic [IW-1:0]   idx;
  logic            carry;
  logic            neg_r;
  logic            err_r;

  // Per-digit arithmetic signals
  logic [3:0]      dig_a;
  logic [3:0]      dig_b;
  logic [3:0]      dig_z;
  logic [4:0]      op1;
  logic [4:0]      op2;
  logic [4:0]      suma;
  logic [4:0]      suma_corr;
  logic [3:0]      digito;
  logic            carry_sig;
  logic            ultimo;
  logic            entrada_invalida;

  // -------------------------------------------------------------------------
  // Input validity: any nibble of A or B above 9 is not a BCD digit.
  // -------------------------------------------------------------------------
  function automatic logic tiene_digito_invalido(input logic [W-1:0] v);
    logic r;
    r = 1'b0;
    for (int i = 0; i < DIGITOS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        r = 1'b1;
      end
    end
    return r;
  endfunction

  assign entrada_invalida = tiene_digito_invalido(A) | tiene_digito_invalido(B);

  // -------------------------------------------------------------------------
  // Digit selection for the current index
  // -------------------------------------------------------------------------
  always_comb begin
    dig_a = a_r[4*idx +: 4];
    dig_b = b_r[4*idx +: 4];
    dig_z = z_r[4*idx +: 4];
  end

  assign ultimo = (idx == IW'(DIGITOS - 1));

  // -------------------------------------------------------------------------
  // One decimal digit adder shared by both passes.
  //   RESTA      : A_i + (9 - B_i) + carry
  //   COMPLEMENTO: (9 - Z_i) + 0   + carry
  // The sum never exceeds 19, so 5 bits are enough, and (s + 6) mod 16 gives
  // the corrected decimal digit whenever s > 9.
  // -------------------------------------------------------------------------
  always_comb begin
    op1 = 5'd0;
    op2 = 5'd0;
    if (estado == COMPLEMENTO) begin
      op1 = {1'b0, 4'd9 - dig_z};
      op2 = 5'd0;
    end else begin
      op1 = {1'b0, dig_a};
      op2 = {1'b0, 4'd9 - dig_b};
    end
  end

  always_comb begin
    suma      = op1 + op2 + {4'd0, carry};
    suma_corr = suma + 5'd6;
    digito    = suma[3:0];
    carry_sig = 1'b0;
    if (suma > 5'd9) begin
      digito    = suma_corr[3:0];
      carry_sig = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      estado <= REPOSO;
    end else begin
      estado <= estado_n;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // An invalid operand is flagged at capture time; RESTA then skips the
  // arithmetic and goes straight to FIN, so the error result arrives one
  // edge after capture.
  // -------------------------------------------------------------------------
  always_comb begin
    estado_n = estado;
    case (estado)
      REPOSO: begin
        if (inicio) begin
          estado_n = RESTA;
        end
      end
      RESTA: begin
        if (err_r) begin
          estado_n = FIN;
        end else if (ultimo) begin
          // Final carry = 1 means A >= B; otherwise the result is negative
          // and needs the complement pass.
          estado_n = carry_sig ? FIN : COMPLEMENTO;
        end
      end
      COMPLEMENTO: begin
        if (ultimo) begin
          estado_n = FIN;
        end
      end
      FIN: begin
        estado_n = REPOSO;
      end
      default: begin
        estado_n = REPOSO;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r   <= '0;
      b_r   <= '0;
      z_r   <= '0;
      idx   <= '0;
      carry <= 1'b0;
      neg_r <= 1'b0;
      err_r <= 1'b0;
    end else begin
      case (estado)
        REPOSO: begin
          if (inicio) begin
            a_r   <= A;
            b_r   <= B;
            z_r   <= '0;
            idx   <= '0;
            carry <= 1'b1;
            neg_r <= 1'b0;
            err_r <= entrada_invalida;
          end
        end
        RESTA: begin
          if (!err_r) begin
            z_r[4*idx +: 4] <= digito;
            if (ultimo) begin
              // The most significant carry becomes the sign and is never
              // written into Z.
              if (carry_sig) begin
                neg_r <= 1'b0;
                carry <= 1'b1;
              end else begin
                neg_r <= 1'b1;
                carry <= 1'b1;
              end
              idx <= '0;
            end else begin
              carry <= carry_sig;
              idx   <= idx + 1'b1;
            end
          end
        end
        COMPLEMENTO: begin
          z_r[4*idx +: 4] <= digito;
          carry           <= carry_sig;
          if (ultimo) begin
            idx <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        FIN: begin
          // Results hold until the next accepted start.
        end
        default: begin
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign Z         = z_r;
  assign negativo  = neg_r;
  assign error_bcd = err_r;
  assign listo     = (estado == FIN);
  assign ocupado   = (estado == RESTA) || (estado == COMPLEMENTO);

endmodule
